// File: rtl/operand_pair_sequencer_pkg.sv
// Shared constants, match-word layout and FSM state for the operand pair sequencer.
package operand_pair_sequencer_pkg;

  localparam int BITMASK_LENGTH = 8;
  localparam int INDEX_BITWIDTH = 3;
  localparam int COUNT_BITWIDTH = 4;
  localparam int IDX_FIELD_W    = BITMASK_LENGTH * INDEX_BITWIDTH;

  localparam int ACT_IDX_LSB = 0;
  localparam int WT_IDX_LSB  = 24;
  localparam int COUNT_LSB   = 48;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Pull packed index number 'slot' out of a 24-bit index field.
  function automatic logic [INDEX_BITWIDTH-1:0] get_idx(
    input logic [IDX_FIELD_W-1:0]    field,
    input logic [INDEX_BITWIDTH-1:0] slot
  );
    return field[INDEX_BITWIDTH*slot +: INDEX_BITWIDTH];
  endfunction

endpackage

// File: rtl/operand_pair_sequencer_slot_mux.sv
// Combinational select of one value out of a packed compressed-value vector.
// Zero latency, no flow control.
module operand_slot_mux
  import operand_pair_sequencer_pkg::*;
#(
  parameter int VALUE_WIDTH = 8
) (
  input  logic [BITMASK_LENGTH*VALUE_WIDTH-1:0] values,
  input  logic [INDEX_BITWIDTH-1:0]             sel,
  output logic [VALUE_WIDTH-1:0]                value
);

  assign value = values[VALUE_WIDTH*sel +: VALUE_WIDTH];

endmodule

// File: rtl/operand_pair_sequencer.sv
// Serialises matched operand pairs to the MAC, one per cycle; first beat one cycle after capture,
// outputs hold under out_ready=0. Optional counters under OPERAND_PAIR_SEQUENCER_STATS_EN.
module operand_pair_sequencer
  import operand_pair_sequencer_pkg::*;
#(
  parameter int VALUE_WIDTH = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [63:0]                           in_match,
  input  logic [BITMASK_LENGTH*VALUE_WIDTH-1:0] in_act_values,
  input  logic [BITMASK_LENGTH*VALUE_WIDTH-1:0] in_wt_values,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [VALUE_WIDTH-1:0]                out_act,
  output logic [VALUE_WIDTH-1:0]                out_wt,
  output logic                                  out_pair_valid,
  output logic                                  out_last,
`ifdef OPERAND_PAIR_SEQUENCER_STATS_EN
  output logic [31:0]                           stat_pairs,
  output logic [31:0]                           stat_stall_cycles,
`endif
  output logic                                  err_count_overflow
);

  localparam int VEC_W = BITMASK_LENGTH * VALUE_WIDTH;
  localparam logic [COUNT_BITWIDTH-1:0] MAX_COUNT = COUNT_BITWIDTH'(BITMASK_LENGTH);

  state_t                    state;
  logic [IDX_FIELD_W-1:0]    act_idx_q;
  logic [IDX_FIELD_W-1:0]    wt_idx_q;
  logic [COUNT_BITWIDTH-1:0] count_q;
  logic [COUNT_BITWIDTH-1:0] p_q;
  logic [VEC_W-1:0]          act_vals_q;
  logic [VEC_W-1:0]          wt_vals_q;

  logic [COUNT_BITWIDTH-1:0] raw_count;
  logic [COUNT_BITWIDTH-1:0] clamped_count;
  logic                      overflow_in;
  logic                      beat_done;
  logic                      block_done;
  logic                      load;
  logic [COUNT_BITWIDTH-1:0] p_nxt;
  logic [VEC_W-1:0]          act_src;
  logic [VEC_W-1:0]          wt_src;
  logic [INDEX_BITWIDTH-1:0] act_sel;
  logic [INDEX_BITWIDTH-1:0] wt_sel;
  logic [VALUE_WIDTH-1:0]    act_mux;
  logic [VALUE_WIDTH-1:0]    wt_mux;
  logic                      unused_match_hi;

  assign unused_match_hi = ^in_match[63:52];

  assign raw_count     = in_match[COUNT_LSB +: COUNT_BITWIDTH];
  assign overflow_in   = raw_count > MAX_COUNT;
  assign clamped_count = overflow_in ? MAX_COUNT : raw_count;

  assign beat_done  = out_valid & out_ready;
  assign block_done = beat_done & out_last;
  assign in_ready   = ~reset & ((state == IDLE) | block_done);
  assign load       = in_valid & in_ready;
  assign p_nxt      = p_q + COUNT_BITWIDTH'(1);

  // On capture the first pair comes straight from the incoming word so beat 0 is ready next cycle.
  assign act_src = load ? in_act_values : act_vals_q;
  assign wt_src  = load ? in_wt_values  : wt_vals_q;
  assign act_sel = load ? get_idx(in_match[ACT_IDX_LSB +: IDX_FIELD_W], '0)
                        : get_idx(act_idx_q, p_nxt[INDEX_BITWIDTH-1:0]);
  assign wt_sel  = load ? get_idx(in_match[WT_IDX_LSB +: IDX_FIELD_W], '0)
                        : get_idx(wt_idx_q, p_nxt[INDEX_BITWIDTH-1:0]);

  operand_slot_mux #(.VALUE_WIDTH(VALUE_WIDTH)) u_act_mux (
    .values (act_src),
    .sel    (act_sel),
    .value  (act_mux)
  );

  operand_slot_mux #(.VALUE_WIDTH(VALUE_WIDTH)) u_wt_mux (
    .values (wt_src),
    .sel    (wt_sel),
    .value  (wt_mux)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      act_idx_q          <= '0;
      wt_idx_q           <= '0;
      count_q            <= '0;
      p_q                <= '0;
      act_vals_q         <= '0;
      wt_vals_q          <= '0;
      out_valid          <= 1'b0;
      out_pair_valid     <= 1'b0;
      out_last           <= 1'b0;
      out_act            <= '0;
      out_wt             <= '0;
      err_count_overflow <= 1'b0;
    end else if (load) begin
      state          <= ISSUE;
      act_idx_q      <= in_match[ACT_IDX_LSB +: IDX_FIELD_W];
      wt_idx_q       <= in_match[WT_IDX_LSB +: IDX_FIELD_W];
      count_q        <= clamped_count;
      p_q            <= '0;
      act_vals_q     <= in_act_values;
      wt_vals_q      <= in_wt_values;
      out_valid      <= 1'b1;
      // An empty block still emits one marker beat with zero operands.
      out_pair_valid <= clamped_count != '0;
      out_last       <= clamped_count <= COUNT_BITWIDTH'(1);
      out_act        <= (clamped_count != '0) ? act_mux : '0;
      out_wt         <= (clamped_count != '0) ? wt_mux  : '0;
      if (overflow_in) err_count_overflow <= 1'b1;
    end else if (beat_done && !out_last) begin
      p_q            <= p_nxt;
      out_pair_valid <= 1'b1;
      out_last       <= p_nxt == (count_q - COUNT_BITWIDTH'(1));
      out_act        <= act_mux;
      out_wt         <= wt_mux;
    end else if (block_done) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      out_pair_valid <= 1'b0;
      out_last       <= 1'b0;
      out_act        <= '0;
      out_wt         <= '0;
    end
  end

`ifdef OPERAND_PAIR_SEQUENCER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_pairs        <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (beat_done && out_pair_valid && (stat_pairs != '1))
        stat_pairs <= stat_pairs + 32'd1;
      if (out_valid && !out_ready && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_pair_sequencer.sv
// Directed bench for operand_pair_sequencer: act slot k holds 10+k, wt slot k holds 20+k.
module tb_operand_pair_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_match = '0;
  logic [63:0] in_act_values;
  logic [63:0] in_wt_values;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_act;
  logic [7:0]  out_wt;
  logic        out_pair_valid;
  logic        out_last;
  logic        err_count_overflow;
`ifdef OPERAND_PAIR_SEQUENCER_STATS_EN
  logic [31:0] stat_pairs;
  logic [31:0] stat_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  operand_pair_sequencer dut (
    .clock              (clock),
    .reset              (reset),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_match           (in_match),
    .in_act_values      (in_act_values),
    .in_wt_values       (in_wt_values),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_act            (out_act),
    .out_wt             (out_wt),
    .out_pair_valid     (out_pair_valid),
    .out_last           (out_last),
`ifdef OPERAND_PAIR_SEQUENCER_STATS_EN
    .stat_pairs         (stat_pairs),
    .stat_stall_cycles  (stat_stall_cycles),
`endif
    .err_count_overflow (err_count_overflow)
  );

  function automatic logic [23:0] pk(input int i0, input int i1, input int i2, input int i3,
                                     input int i4, input int i5, input int i6, input int i7);
    return {i7[2:0], i6[2:0], i5[2:0], i4[2:0], i3[2:0], i2[2:0], i1[2:0], i0[2:0]};
  endfunction

  function automatic logic [63:0] mk(input int cnt, input logic [23:0] a, input logic [23:0] w);
    return {12'hABC, 4'(cnt), w, a};
  endfunction

  function automatic logic [18:0] beat(input bit last, input int act, input int wt);
    return {1'b1, 1'b1, last, 8'(act), 8'(wt)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({in_ready, out_valid, out_pair_valid, out_last, out_act, out_wt, err_count_overflow} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state got %h exp 0",
               {in_ready, out_valid, out_pair_valid, out_last, out_act, out_wt, err_count_overflow});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int ea[3] = '{10, 11, 12};
    int ew[3] = '{20, 22, 25};
    logic [18:0] got;
    @(negedge clock);
    in_match  = mk(3, pk(0, 1, 2, 0, 0, 0, 0, 0), pk(0, 2, 5, 0, 0, 0, 0, 0));
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      got = {out_valid, out_pair_valid, out_last, out_act, out_wt};
      checks++;
      if (got !== beat(b == 2, ea[b], ew[b])) begin
        errors++;
        $display("FAIL basic_beat%0d got %h exp %h", b, got, beat(b == 2, ea[b], ew[b]));
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_end_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_count0();
    logic [18:0] got;
    @(negedge clock);
    in_match = mk(0, pk(3, 3, 3, 3, 3, 3, 3, 3), pk(4, 4, 4, 4, 4, 4, 4, 4));
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    got = {out_valid, out_pair_valid, out_last, out_act, out_wt};
    checks++;
    if (got !== 19'b101_00000000_00000000) begin
      errors++;
      $display("FAIL count0_beat got %h exp %h", got, 19'b101_00000000_00000000);
    end
    @(negedge clock);
    #1;
    checks++;
    if ({out_valid, err_count_overflow} !== 2'b00) begin
      errors++;
      $display("FAIL count0_end got %b exp 00", {out_valid, err_count_overflow});
    end
  endtask

  task automatic test_stall();
    int ea[8] = '{17, 16, 15, 14, 13, 12, 11, 10};
    int ew[8] = '{23, 21, 24, 21, 25, 22, 26, 20};
    int b = 0;
    bit rdy = 1'b1;
    logic [18:0] got;
    @(negedge clock);
    in_match = mk(8, pk(7, 6, 5, 4, 3, 2, 1, 0), pk(3, 1, 4, 1, 5, 2, 6, 0));
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && b < 8; cyc++) begin
      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = rdy;
      #1;
      got = {out_valid, out_pair_valid, out_last, out_act, out_wt};
      checks++;
      if (got !== beat(b == 7, ea[b], ew[b])) begin
        errors++;
        $display("FAIL stall_beat%0d rdy=%0b got %h exp %h", b, rdy, got, beat(b == 7, ea[b], ew[b]));
      end
      if (rdy) b++;
      rdy = ~rdy;
    end
    checks++;
    if (b != 8) begin
      errors++;
      $display("FAIL stall_timeout beats %0d exp 8", b);
    end
    out_ready = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_end_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int ea[4] = '{10, 11, 13, 14};
    int ew[4] = '{21, 20, 26, 27};
    logic [18:0] got;
    @(negedge clock);
    out_ready = 1'b1;
    in_match  = mk(2, pk(0, 1, 0, 0, 0, 0, 0, 0), pk(1, 0, 0, 0, 0, 0, 0, 0));
    in_valid  = 1'b1;
    @(negedge clock);
    in_match = mk(2, pk(3, 4, 0, 0, 0, 0, 0, 0), pk(6, 7, 0, 0, 0, 0, 0, 0));
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        @(negedge clock);
        in_valid = 1'b0;
      end else if (b != 0) begin
        @(negedge clock);
      end
      #1;
      got = {out_valid, out_pair_valid, out_last, out_act, out_wt};
      checks++;
      if (got !== beat(b[0], ea[b], ew[b])) begin
        errors++;
        $display("FAIL b2b_beat%0d got %h exp %h", b, got, beat(b[0], ea[b], ew[b]));
      end
      if (b < 2) begin
        checks++;
        if (in_ready !== (b == 1)) begin
          errors++;
          $display("FAIL b2b_in_ready%0d got %b exp %b", b, in_ready, b == 1);
        end
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    int b = 0;
    logic [18:0] got;
    @(negedge clock);
    out_ready = 1'b1;
    in_match  = mk(12, pk(0, 1, 2, 3, 4, 5, 6, 7), pk(7, 6, 5, 4, 3, 2, 1, 0));
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      if (!out_valid) break;
      got = {out_valid, out_pair_valid, out_last, out_act, out_wt};
      checks++;
      if (got !== beat(b == 7, 10 + b, 27 - b)) begin
        errors++;
        $display("FAIL ovf_beat%0d got %h exp %h", b, got, beat(b == 7, 10 + b, 27 - b));
      end
      b++;
    end
    checks++;
    if (b != 8 || err_count_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_beats_err got beats=%0d err=%b exp beats=8 err=1", b, err_count_overflow);
    end
    in_match = mk(1, pk(2, 0, 0, 0, 0, 0, 0, 0), pk(3, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    got = {out_valid, out_pair_valid, out_last, out_act, out_wt};
    checks++;
    if (got !== beat(1'b1, 12, 23) || err_count_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_next_block got %h err=%b exp %h err=1", got, err_count_overflow, beat(1'b1, 12, 23));
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    logic [18:0] got;
    @(negedge clock);
    out_ready = 1'b1;
    in_match  = mk(5, pk(0, 1, 2, 3, 4, 5, 6, 7), pk(4, 3, 2, 1, 0, 7, 6, 5));
    in_valid  = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    #1;
    got = {out_valid, out_pair_valid, out_last, out_act, out_wt};
    checks++;
    if (got !== beat(1'b0, 11, 23)) begin
      errors++;
      $display("FAIL rst_mid_beat1 got %h exp %h", got, beat(1'b0, 11, 23));
    end
    // Reset on beat 2, with a new word offered in the same cycle: reset wins.
    reset    = 1'b1;
    in_match = mk(2, pk(5, 6, 0, 0, 0, 0, 0, 0), pk(1, 2, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if ({in_ready, out_valid, out_pair_valid, out_last, out_act, out_wt, err_count_overflow} !== 21'd0) begin
      errors++;
      $display("FAIL rst_mid_state got %h exp 0",
               {in_ready, out_valid, out_pair_valid, out_last, out_act, out_wt, err_count_overflow});
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_in_ready got %b exp 1", in_ready);
    end
    for (int b = 0; b < 2; b++) begin
      @(negedge clock);
      in_valid = 1'b0;
      #1;
      got = {out_valid, out_pair_valid, out_last, out_act, out_wt};
      checks++;
      if (got !== beat(b == 1, 15 + b, 21 + b)) begin
        errors++;
        $display("FAIL rst_mid_new%0d got %h exp %h", b, got, beat(b == 1, 15 + b, 21 + b));
      end
    end
    @(negedge clock);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      in_act_values[8*k +: 8] = 8'(10 + k);
      in_wt_values[8*k +: 8]  = 8'(20 + k);
    end
    test_reset();
    test_basic();
    test_count0();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
